feature_map_writer: RTL and testbench
=====================================

# feature_map_writer

Receive end of the convolutional layer's output stream. Captures each `valid`-qualified `Q_CHANNELS`-wide result word into an on-chip feature-map RAM in raster order. Flags frame completion and holds the frame until the consumer acknowledges it. Exposes a registered random-access read port for the next layer or the host.

## Interface
- `Q_WIDTH`, default 16: bits per output-channel value (two's complement).
- `Q_CHANNELS`, default 4: channels per stream word.
- `OUT_SIZE`, default 26: feature-map side length, equal to IMAGE_SIZE-FILTER_SIZE+1 of the producing layer; depth = `OUT_SIZE`².
- `ADDR_W`, default `LOG2(OUT_SIZE*OUT_SIZE)`: RAM address width.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `clk_en`  in  1: stream clock enable, shared with the producer.
- `input_data`  in  `Q_WIDTH*Q_CHANNELS`: result word from the producer.
- `valid`  in  1: `input_data` is a real window result (qualified by `clk_en`).
- `frame_ack`  in  1: consumer releases the completed frame.
- `rd_en`  in  1: read request.
- `rd_addr`  in  `ADDR_W`: read address, raster index row*`OUT_SIZE`+col.
- `rd_data`  out  `Q_WIDTH*Q_CHANNELS`: read data.
- `rd_valid`  out  1: `rd_data` valid this cycle.
- `frame_done`  out  1: full frame stored, awaiting ack.
- `wr_count`  out  `ADDR_W+1`: words captured in the current frame.
- `overflow`  out  1: sticky; a beat arrived while no frame slot was free.

## Operation
- Beat = cycle with `clk_en`=1 and `valid`=1. Beats with `clk_en`=0 are ignored regardless of `valid`.
- FSM has two states, FILL (reset state) and HOLD.
  - FILL: each beat writes `input_data` to RAM[`wr_ptr`] and increments `wr_ptr`. On the beat writing address `OUT_SIZE`²-1, go to HOLD, set `frame_done`=1 and wrap `wr_ptr` to 0.
  - HOLD: no RAM writes. Any beat sets `overflow`=1 and the data is discarded.
  - HOLD with `frame_ack`=1: next cycle goes to FILL and `frame_done`=0. A beat in that same cycle is still dropped and still sets `overflow`.
  - `frame_ack` in FILL is ignored.
- `wr_count` = `wr_ptr` in FILL and `OUT_SIZE`² in HOLD.
- Read port works in both states.
  - `rd_data` = RAM[`rd_addr`] sampled at the `rd_en` edge. `rd_data` holds its last value when `rd_en`=0.
  - Same-address read and write in one cycle is read-first: it returns the old word.
  - `rd_addr` ≥ `OUT_SIZE`² returns don't-care data, but `rd_valid` still asserts.
- `overflow` clears only on `rst`.
- Reset mid-frame:
  - Next cycle state=FILL, `wr_ptr`=0, `frame_done`=0, `overflow`=0, `rd_valid`=0, `rd_data`=0.
  - RAM contents are not cleared.
  - A beat coincident with `rst` is not written.

## Timing
- Write latency: a beat at edge N is readable by a read issued at edge N+1.
- Read latency: exactly 1 cycle. `rd_en` at edge N gives `rd_data` and `rd_valid`=1 after edge N. `rd_valid`=0 after any edge with `rd_en`=0.
- `frame_done` rises after the edge capturing the last beat and falls after the edge sampling `frame_ack` in HOLD.
- Throughput: one beat per cycle sustained with no stalls. There is no backpressure to the producer; `overflow` is the only indication of loss.
- All outputs are registered.

## Configuration
- `FEATURE_MAP_RELU_EN` defined: each `Q_WIDTH` lane is passed through ReLU before the RAM write. A negative lane (MSB=1) is stored as 0; otherwise it is stored unchanged.
- Not defined: lanes are stored verbatim, and no compare logic is instantiated.

## Structure
- The `LOG2` macro and the lane-slicing macros `L`/`R` come from the common definitions file.
- The FSM state encodings (FILL=0, HOLD=1) are also defined there as constants.
- One sub-module, `feature_map_ram`: simple dual-port synchronous RAM with 1 write and 1 read port, read-first, width `Q_WIDTH*Q_CHANNELS`, depth `OUT_SIZE`².
- Pointer and counter logic, FSM and the ReLU lanes live in the top.

## Test plan
- `OUT_SIZE`=3, `Q_CHANNELS`=2, `Q_WIDTH`=8; drive 9 beats with lanes {i, i+1}, i=0..8 → `frame_done`=1 after the 9th beat, `wr_count`=9, reads of addresses 0..8 return {i, i+1} with 1-cycle latency.
- Same config, beats interleaved with `clk_en`=0/`valid`=1 and `clk_en`=1/`valid`=0 cycles → only qualified beats are stored, at consecutive addresses 0..8.
- Fill the frame, then send 2 more beats in HOLD → `overflow`=1, RAM unchanged. Then pulse `frame_ack` → FILL, `wr_count`=0, and the next beat lands at address 0.
- `rst` after 5 beats → all outputs 0. The next 9 beats refill from address 0, and `frame_done` rises after the 9th.
- With `FEATURE_MAP_RELU_EN`: lanes {-5, 7} → stored {0, 7}. Without the macro → stored {8'hFB, 7}.
- Read of address 4 in the same cycle as the beat writing address 4 → returns the prior word. A read on the next cycle returns the new word.

Source files
------------

// File: rtl/feature_map_writer_pkg.sv
// rtl/feature_map_writer_pkg.sv - shared types and helpers for the feature-map writer
package feature_map_writer_pkg;

   // Capture FSM: FILL (reset state, accepting beats) and HOLD (frame parked until ack)
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } fm_state_t;

   // Address width needed to index a square map of the given side length
   function automatic int fm_addr_w(input int side);
      return (side * side > 1) ? $clog2(side * side) : 1;
   endfunction

   // Low bit of a lane inside a packed multi-channel word
   function automatic int fm_lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/feature_map_ram.sv
// rtl/feature_map_ram.sv - simple dual-port read-first RAM holding one feature map
module feature_map_ram #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 676,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   logic [WIDTH-1:0] r_mem [0:DEPTH-1];
   logic [WIDTH-1:0] r_rd_data;

   // Write port; the array is never reset so it maps onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port; sampling the array before the write lands gives read-first
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[rd_addr];
      end
   end

   assign rd_data = r_rd_data;

endmodule

// File: rtl/feature_map_writer.sv
// rtl/feature_map_writer.sv - captures a conv-layer output frame into RAM (optional FEATURE_MAP_RELU_EN)
module feature_map_writer
   import feature_map_writer_pkg::*;
#(
   parameter int Q_WIDTH    = 16,
   parameter int Q_CHANNELS = 4,
   parameter int OUT_SIZE   = 26,
   parameter int ADDR_W     = fm_addr_w(OUT_SIZE)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clk_en,
   input  logic [Q_WIDTH*Q_CHANNELS-1:0] input_data,
   input  logic                          valid,
   input  logic                          frame_ack,
   input  logic                          rd_en,
   input  logic [ADDR_W-1:0]             rd_addr,
   output logic [Q_WIDTH*Q_CHANNELS-1:0] rd_data,
   output logic                          rd_valid,
   output logic                          frame_done,
   output logic [ADDR_W:0]               wr_count,
   output logic                          overflow
);

   localparam int DEPTH = OUT_SIZE * OUT_SIZE;
   localparam int WORD_W = Q_WIDTH * Q_CHANNELS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

   fm_state_t         r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W:0]   r_wr_count;
   logic              r_frame_done;
   logic              r_overflow;
   logic              r_rd_valid;

   logic              w_beat;
   logic              w_wr_en;
   logic [WORD_W-1:0] w_wr_data;

   assign w_beat  = clk_en & valid;
   // A beat coincident with reset must not reach the RAM
   assign w_wr_en = w_beat & (r_state == FILL) & ~rst;

`ifdef FEATURE_MAP_RELU_EN
   // Clamp negative lanes to zero before they are stored
   for (genvar g = 0; g < Q_CHANNELS; g++) begin : g_relu
      assign w_wr_data[fm_lane_lo(g, Q_WIDTH) +: Q_WIDTH] =
         input_data[fm_lane_lo(g, Q_WIDTH) + Q_WIDTH - 1] ? '0
                                                          : input_data[fm_lane_lo(g, Q_WIDTH) +: Q_WIDTH];
   end
`else
   assign w_wr_data = input_data;
`endif

   // Capture FSM with write pointer, word count, frame flag and sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FILL;
         r_wr_ptr     <= '0;
         r_wr_count   <= '0;
         r_frame_done <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_beat) begin
                  if (r_wr_ptr == LAST_ADDR) begin
                     r_state      <= HOLD;
                     r_wr_ptr     <= '0;
                     r_wr_count   <= FULL_COUNT;
                     r_frame_done <= 1'b1;
                  end else begin
                     r_wr_ptr   <= r_wr_ptr + 1'b1;
                     r_wr_count <= {1'b0, r_wr_ptr + 1'b1};
                  end
               end
            end
            HOLD: begin
               if (w_beat) begin
                  r_overflow <= 1'b1;
               end
               if (frame_ack) begin
                  r_state      <= FILL;
                  r_wr_count   <= '0;
                  r_frame_done <= 1'b0;
               end
            end
            default: begin
               r_state <= FILL;
            end
         endcase
      end
   end

   // Read-valid tracks the read request with one cycle of latency
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= rd_en;
      end
   end

   feature_map_ram #(
      .WIDTH  (WORD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en),
      .wr_addr (r_wr_ptr),
      .wr_data (w_wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign rd_valid   = r_rd_valid;
   assign frame_done = r_frame_done;
   assign wr_count   = r_wr_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_feature_map_writer.sv
// tb/tb_feature_map_writer.sv - randomized self-checking bench for feature_map_writer
module tb_feature_map_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        valid;
   logic        frame_ack;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [15:0] input_data;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        frame_done;
   logic [4:0]  wr_count;
   logic        overflow;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural reference: words held, frame-full flag, sticky loss flag, map contents
   int          m_count;
   bit          m_full;
   bit          m_ovf;
   bit          m_rdv;
   bit          m_rd_known;
   logic [15:0] m_rd;
   logic [15:0] m_ram [0:8];

   feature_map_writer #(
      .Q_WIDTH    (8),
      .Q_CHANNELS (2),
      .OUT_SIZE   (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .input_data (input_data),
      .valid      (valid),
      .frame_ack  (frame_ack),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .frame_done (frame_done),
      .wr_count   (wr_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] relu_ref(input logic [15:0] d);
      logic [15:0] r;
      r = d;
`ifdef FEATURE_MAP_RELU_EN
      if (r[7])  r[7:0]  = 8'h00;
      if (r[15]) r[15:8] = 8'h00;
`endif
      return r;
   endfunction

   // Apply one cycle of inputs, advance the reference by the frame rules, settle past the edge
   task automatic tick(input bit ce, input bit v, input logic [15:0] d, input bit ack,
                       input bit re, input logic [3:0] ra, input bit r);
      rst = r; clk_en = ce; valid = v; input_data = d; frame_ack = ack; rd_en = re; rd_addr = ra;
      @(posedge clk);
      if (r) begin
         m_count = 0; m_full = 0; m_ovf = 0; m_rdv = 0; m_rd = '0; m_rd_known = 1;
      end else begin
         if (re) begin
            m_rdv = 1;
            if (ra < 9) begin
               m_rd = m_ram[ra];
               m_rd_known = 1;
            end else begin
               m_rd_known = 0;
            end
         end else begin
            m_rdv = 0;
         end
         if (m_full) begin
            if (ce && v) m_ovf = 1;
            if (ack) begin
               m_full = 0;
               m_count = 0;
            end
         end else if (ce && v) begin
            m_ram[m_count] = relu_ref(d);
            m_count++;
            if (m_count == 9) m_full = 1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 16'h1234, 0, 1, 4'd0, 1);
      tick(0, 0, 16'h0, 0, 0, 4'd0, 1);
      n_total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else n_pass++;
      n_total++; if (wr_count !== 5'd0) $display("FAIL reset_wr_count got %0d want 0", wr_count); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else n_pass++;
      n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
      n_total++; if (rd_data !== 16'h0) $display("FAIL reset_rd_data got %h want 0000", rd_data); else n_pass++;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 9; i++) begin
         tick(1, 1, {8'(i + 1), 8'(i)}, 0, 0, 4'd0, 0);
         n_total++; if (wr_count !== 5'(m_count)) $display("FAIL fill_wr_count got %0d want %0d", wr_count, m_count); else n_pass++;
         n_total++; if (frame_done !== m_full) $display("FAIL fill_frame_done got %b want %b", frame_done, m_full); else n_pass++;
      end
      n_total++; if (wr_count !== 5'd9) $display("FAIL fill_full_count got %0d want 9", wr_count); else n_pass++;
      for (int a = 0; a < 9; a++) begin
         tick(0, 0, 16'h0, 0, 1, 4'(a), 0);
         n_total++; if (rd_valid !== 1'b1) $display("FAIL fill_rd_valid got %b want 1", rd_valid); else n_pass++;
         n_total++; if (rd_data !== {8'(a + 1), 8'(a)}) $display("FAIL fill_rd_data addr %0d got %h want %h", a, rd_data, {8'(a + 1), 8'(a)}); else n_pass++;
      end
      tick(0, 0, 16'h0, 0, 0, 4'd0, 0);
      n_total++; if (rd_valid !== 1'b0) $display("FAIL idle_rd_valid got %b want 0", rd_valid); else n_pass++;
      n_total++; if (rd_data !== m_rd) $display("FAIL idle_rd_hold got %h want %h", rd_data, m_rd); else n_pass++;
   endtask

   task automatic test_hold_overflow();
      logic [15:0] d;
      for (int k = 0; k < 2; k++) begin
         d = 16'($urandom);
         tick(1, 1, d, 0, 0, 4'd0, 0);
         n_total++; if (overflow !== 1'b1) $display("FAIL hold_overflow got %b want 1", overflow); else n_pass++;
         n_total++; if (frame_done !== 1'b1) $display("FAIL hold_frame_done got %b want 1", frame_done); else n_pass++;
      end
      for (int a = 0; a < 9; a++) begin
         tick(0, 0, 16'h0, 0, 1, 4'(a), 0);
         n_total++; if (rd_data !== m_rd) $display("FAIL hold_ram addr %0d got %h want %h", a, rd_data, m_rd); else n_pass++;
      end
      tick(1, 1, 16'($urandom), 1, 0, 4'd0, 0);
      n_total++; if (frame_done !== 1'b0) $display("FAIL ack_frame_done got %b want 0", frame_done); else n_pass++;
      n_total++; if (wr_count !== 5'd0) $display("FAIL ack_wr_count got %0d want 0", wr_count); else n_pass++;
      n_total++; if (overflow !== 1'b1) $display("FAIL ack_overflow got %b want 1", overflow); else n_pass++;
      d = 16'($urandom);
      tick(1, 1, d, 0, 0, 4'd0, 0);
      tick(0, 0, 16'h0, 1, 1, 4'd0, 0);
      n_total++; if (rd_data !== relu_ref(d)) $display("FAIL refill_addr0 got %h want %h", rd_data, relu_ref(d)); else n_pass++;
      n_total++; if (wr_count !== 5'd1 || frame_done !== 1'b0) $display("FAIL fill_ack_ignored got %0d/%b want 1/0", wr_count, frame_done); else n_pass++;
   endtask

   task automatic test_gaps();
      int cyc;
      tick(0, 0, 16'h0, 0, 0, 4'd0, 1);
      cyc = 0;
      while (!m_full && cyc < 300) begin
         tick(1'($urandom), 1'($urandom), 16'($urandom), 0, 0, 4'd0, 0);
         cyc++;
         n_total++; if (wr_count !== 5'(m_count)) $display("FAIL gaps_wr_count got %0d want %0d", wr_count, m_count); else n_pass++;
      end
      n_total++; if (frame_done !== 1'b1) $display("FAIL gaps_frame_done got %b want 1 after %0d cycles", frame_done, cyc); else n_pass++;
      for (int a = 0; a < 9; a++) begin
         tick(0, 0, 16'h0, 0, 1, 4'(a), 0);
         n_total++; if (rd_data !== m_rd) $display("FAIL gaps_ram addr %0d got %h want %h", a, rd_data, m_rd); else n_pass++;
      end
   endtask

   task automatic test_rst_mid();
      tick(0, 0, 16'h0, 0, 0, 4'd0, 1);
      for (int i = 0; i < 5; i++) tick(1, 1, 16'($urandom) | 16'h0101, 0, 0, 4'd0, 0);
      tick(0, 0, 16'h0, 0, 1, 4'd2, 0);
      tick(1, 1, 16'h5A5A, 0, 1, 4'd1, 1);
      n_total++; if (wr_count !== 5'd0 || frame_done !== 1'b0 || overflow !== 1'b0) $display("FAIL rst_mid_state got %0d/%b/%b want 0/0/0", wr_count, frame_done, overflow); else n_pass++;
      n_total++; if (rd_valid !== 1'b0 || rd_data !== 16'h0) $display("FAIL rst_mid_read got %b/%h want 0/0000", rd_valid, rd_data); else n_pass++;
      tick(0, 0, 16'h0, 0, 1, 4'd5, 0);
      n_total++; if (rd_data !== m_rd) $display("FAIL rst_beat_dropped got %h want %h", rd_data, m_rd); else n_pass++;
      for (int i = 0; i < 9; i++) begin
         tick(1, 1, 16'($urandom), 0, 0, 4'd0, 0);
         n_total++; if (frame_done !== (i == 8)) $display("FAIL refill_frame_done beat %0d got %b want %b", i, frame_done, (i == 8)); else n_pass++;
      end
      for (int a = 0; a < 9; a++) begin
         tick(0, 0, 16'h0, 0, 1, 4'(a), 0);
         n_total++; if (rd_data !== m_rd) $display("FAIL refill_ram addr %0d got %h want %h", a, rd_data, m_rd); else n_pass++;
      end
   endtask

   task automatic test_relu();
      logic [15:0] want;
`ifdef FEATURE_MAP_RELU_EN
      want = 16'h0700;
`else
      want = 16'h07FB;
`endif
      tick(0, 0, 16'h0, 0, 0, 4'd0, 1);
      tick(1, 1, 16'h07FB, 0, 0, 4'd0, 0);
      tick(0, 0, 16'h0, 0, 1, 4'd0, 0);
      n_total++; if (rd_data !== want) $display("FAIL relu_lane got %h want %h", rd_data, want); else n_pass++;
      n_total++; if (rd_data !== m_rd) $display("FAIL relu_model got %h want %h", rd_data, m_rd); else n_pass++;
   endtask

   task automatic test_collision();
      logic [15:0] d;
      logic [15:0] old;
      tick(0, 0, 16'h0, 0, 0, 4'd0, 1);
      for (int i = 0; i < 4; i++) tick(1, 1, 16'($urandom), 0, 0, 4'd0, 0);
      old = m_ram[4];
      d = ~old;
      tick(1, 1, d, 0, 1, 4'd4, 0);
      n_total++; if (rd_data !== old) $display("FAIL collide_read_first got %h want %h", rd_data, old); else n_pass++;
      tick(0, 0, 16'h0, 0, 1, 4'd4, 0);
      n_total++; if (rd_data !== relu_ref(d)) $display("FAIL collide_next_read got %h want %h", rd_data, relu_ref(d)); else n_pass++;
      tick(0, 0, 16'h0, 0, 1, 4'd12, 0);
      n_total++; if (rd_valid !== 1'b1 || m_rd_known) $display("FAIL oob_rd_valid got %b want 1", rd_valid); else n_pass++;
   endtask

   initial begin
      rst = 1'b1; clk_en = 1'b0; valid = 1'b0; input_data = '0;
      frame_ack = 1'b0; rd_en = 1'b0; rd_addr = '0;
      m_count = 0; m_full = 0; m_ovf = 0; m_rdv = 0; m_rd = '0; m_rd_known = 1;
      #2;
      test_reset();
      test_fill();
      test_hold_overflow();
      test_gaps();
      test_rst_mid();
      test_relu();
      test_collision();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
